axi_esdi_cmd_master: RTL and testbench

Controller-side (initiator) ESDI serial command port, managed through an AXI4-Lite CSR block. Software writes a 16-bit command. The block shifts it out as 17 bits with odd parity on esdi_command_data, handshaking each bit with esdi_transfer_req/esdi_transfer_ack. Optionally it clocks back a 17-bit config/status word, then waits for esdi_command_complete. It sits on the host-adapter FPGA, facing the drive-side ESDI command interface.

---
 rtl/axi_esdi_cmd_master_if.sv | 36 +++
 rtl/axi_esdi_cmd_master.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_axi_esdi_cmd_master.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_esdi_cmd_master_if.sv
// AXI4-Lite CSR bus for the ESDI command master.
// master = bus initiator (host/bench), slave = axi_esdi_cmd_master.
`timescale 1ns/1ps
interface axi_esdi_cmd_master_if;
    logic        awvalid;
    logic        awready;
    logic [4:0]  awaddr;
    logic [2:0]  awprot;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        bvalid;
    logic        bready;
    logic [1:0]  bresp;
    logic        arvalid;
    logic        arready;
    logic [4:0]  araddr;
    logic [2:0]  arprot;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, awprot, wvalid, wdata, wstrb, bready,
               arvalid, araddr, arprot, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/axi_esdi_cmd_master.sv
// ESDI serial command initiator: shifts {cmd, odd parity} to the drive bit by bit,
// optionally clocks back a 17-bit config/status word, then waits for command_complete.
`timescale 1ns/1ps
module axi_esdi_cmd_master #(
    parameter int DATA_SETUP   = 6,
    parameter int ACK_TIMEOUT  = 1_000_000,
    parameter int CMPL_TIMEOUT = 1_000_000
) (
    input  logic                 csr_aclk,
    input  logic                 csr_aresetn,
    axi_esdi_cmd_master_if.slave csr,
    output logic                 interrupt,
    output logic                 esdi_transfer_req,
    output logic                 esdi_command_data,
    input  logic                 esdi_transfer_ack,
    input  logic                 esdi_confstat_data,
    input  logic                 esdi_command_complete,
    input  logic                 esdi_attention,
    input  logic                 esdi_ready,
    input  logic                 esdi_drive_selected
);
    localparam logic [31:0] SETUP_LAST = 32'(DATA_SETUP - 1);
    localparam logic [31:0] ACK_LAST   = 32'(ACK_TIMEOUT - 1);
    localparam logic [31:0] CMPL_LAST  = 32'(CMPL_TIMEOUT - 1);

    localparam logic [2:0] A_CTRL   = 3'd0;
    localparam logic [2:0] A_STATUS = 3'd1;
    localparam logic [2:0] A_CMD    = 3'd2;
    localparam logic [2:0] A_RESP   = 3'd3;
    localparam logic [2:0] A_IRQ    = 3'd4;

    localparam logic [2:0] E_ACK   = 3'd1;
    localparam logic [2:0] E_PAR   = 3'd2;
    localparam logic [2:0] E_CMPL  = 3'd3;
    localparam logic [2:0] E_ATTN  = 3'd4;
    localparam logic [2:0] E_START = 3'd5;

    typedef enum logic [2:0] {
        IDLE, SETUP, REQ, REL, RX_REQ, RX_REL, CMPL, DONE
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [5:0] meta_q;
    logic [5:0] sync_q;
    logic       ack_s, conf_s, cmpl_s, att_s, rdy_s, sel_s;

    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= {esdi_transfer_ack, esdi_confstat_data, esdi_command_complete,
                       esdi_attention, esdi_ready, esdi_drive_selected};
            sync_q <= meta_q;
        end
    end

    assign {ack_s, conf_s, cmpl_s, att_s, rdy_s, sel_s} = sync_q;

    // ------------------------------------------------------------------
    // AXI4-Lite slave: aw/w captured independently, committed together
    // ------------------------------------------------------------------
    logic        ready_en_q;
    logic        aw_held_q, w_held_q, bvalid_q, rvalid_q;
    logic [2:0]  waddr_q;
    logic [15:0] wdata_q;
    logic        wstrb0_q;
    logic [31:0] rdata_q;
    logic [31:0] rd_mux;
    logic        aw_fire, w_fire, ar_fire, wr_commit;

    assign csr.awready = ready_en_q && !aw_held_q && !bvalid_q;
    assign csr.wready  = ready_en_q && !w_held_q && !bvalid_q;
    assign csr.arready = ready_en_q && !rvalid_q;
    assign csr.bvalid  = bvalid_q;
    assign csr.bresp   = 2'b00;
    assign csr.rvalid  = rvalid_q;
    assign csr.rdata   = rdata_q;
    assign csr.rresp   = 2'b00;

    assign aw_fire   = csr.awvalid && csr.awready;
    assign w_fire    = csr.wvalid && csr.wready;
    assign ar_fire   = csr.arvalid && csr.arready;
    assign wr_commit = aw_held_q && w_held_q && !bvalid_q;

    logic unused_bits;
    assign unused_bits = ^{csr.awaddr[1:0], csr.araddr[1:0], csr.awprot, csr.arprot,
                           csr.wstrb[3:1], csr.wdata[31:16]};

    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            ready_en_q <= 1'b0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            wstrb0_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (aw_fire) begin
                aw_held_q <= 1'b1;
                waddr_q   <= csr.awaddr[4:2];
            end
            if (w_fire) begin
                w_held_q <= 1'b1;
                wdata_q  <= csr.wdata[15:0];
                wstrb0_q <= csr.wstrb[0];
            end
            if (wr_commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
            end else if (bvalid_q && csr.bready) begin
                bvalid_q <= 1'b0;
            end
            if (ar_fire) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_mux;
            end else if (rvalid_q && csr.rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [16:0] tx_q, tx_d;
    logic [16:0] rx_q, rx_d;
    logic [16:0] resp_q, resp_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic        done_q, done_d;
    logic [2:0]  err_q, err_d;
    logic        att_prev_q;
    logic        req_q, cmd_data_q;
    logic [2:0]  fsm_err, err_set;
    logic        busy, abort, cmd_accept, start_ok, start_fail, irq_clear, att_rise, rx_par_bad;

    assign busy       = (state_q != IDLE) && (state_q != DONE);
    assign abort      = ctrl_q[0] || !ctrl_q[1];
    assign cmd_accept = wr_commit && (waddr_q == A_CMD) && !abort && (state_q == IDLE);
    assign start_ok   = cmd_accept && sel_s && rdy_s;
    assign start_fail = cmd_accept && !(sel_s && rdy_s);
    assign irq_clear  = wr_commit && (waddr_q == A_IRQ) && wstrb0_q && wdata_q[0];
    assign att_rise   = att_s && !att_prev_q && busy;
    assign rx_par_bad = (~^rx_q[16:1]) != rx_q[0];

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        resp_d  = resp_q;
        fsm_err = 3'd0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = SETUP;
                    bit_d   = '0;
                    tx_d    = {wdata_q, ~^wdata_q};
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) state_d = REQ;
            end
            REQ: begin
                if (ack_s) begin
                    state_d = REL;
                end else if (cnt_q == ACK_LAST) begin
                    fsm_err = E_ACK;
                    state_d = DONE;
                end
            end
            REL: begin
                if (!ack_s) begin
                    if (bit_q == 5'd16) begin
                        bit_d   = '0;
                        state_d = ctrl_q[2] ? RX_REQ : CMPL;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        tx_d    = {tx_q[15:0], 1'b0};
                        state_d = SETUP;
                    end
                end else if (cnt_q == ACK_LAST) begin
                    fsm_err = E_ACK;
                    state_d = DONE;
                end
            end
            RX_REQ: begin
                if (ack_s) begin
                    rx_d    = {rx_q[15:0], conf_s};
                    state_d = RX_REL;
                end else if (cnt_q == ACK_LAST) begin
                    fsm_err = E_ACK;
                    state_d = DONE;
                end
            end
            RX_REL: begin
                if (!ack_s) begin
                    if (bit_q == 5'd16) begin
                        resp_d  = {rx_par_bad, rx_q[16:1]};
                        fsm_err = rx_par_bad ? E_PAR : 3'd0;
                        state_d = CMPL;
                    end else begin
                        bit_d   = bit_q + 5'd1;
                        state_d = RX_REQ;
                    end
                end else if (cnt_q == ACK_LAST) begin
                    fsm_err = E_ACK;
                    state_d = DONE;
                end
            end
            CMPL: begin
                if (cmpl_s) begin
                    state_d = DONE;
                end else if (cnt_q == CMPL_LAST) begin
                    fsm_err = E_CMPL;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) begin
            state_d = IDLE;
            resp_d  = '0;
        end
    end

    assign cnt_d = ((state_d != state_q) || (state_q == IDLE)) ? 32'd0 : cnt_q + 32'd1;

    // Only the first error is kept; a clear and a new error in the same cycle keeps the new one.
    always_comb begin
        ctrl_d  = ctrl_q;
        done_d  = done_q;
        err_d   = err_q;
        err_set = fsm_err;
        if (att_rise && (err_set == 3'd0)) err_set = E_ATTN;
        if (start_fail) err_set = E_START;
        if (wr_commit && (waddr_q == A_CTRL) && wstrb0_q) ctrl_d = wdata_q[2:0];
        if (irq_clear) begin
            done_d = 1'b0;
            err_d  = 3'd0;
        end
        if (err_d == 3'd0) err_d = err_set;
        if ((state_q == DONE) || start_fail) done_d = 1'b1;
        if (abort) begin
            done_d = 1'b0;
            err_d  = 3'd0;
        end
    end

    always_ff @(posedge csr_aclk or negedge csr_aresetn) begin
        if (!csr_aresetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            resp_q     <= '0;
            ctrl_q     <= '0;
            done_q     <= 1'b0;
            err_q      <= '0;
            att_prev_q <= 1'b0;
            req_q      <= 1'b0;
            cmd_data_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            resp_q     <= resp_d;
            ctrl_q     <= ctrl_d;
            done_q     <= done_d;
            err_q      <= err_d;
            att_prev_q <= att_s;
            req_q      <= (state_d == REQ) || (state_d == RX_REQ);
            cmd_data_q <= ((state_d == SETUP) || (state_d == REQ) || (state_d == REL)) ? tx_d[16] : 1'b0;
        end
    end

    always_comb begin
        rd_mux = 32'h0;
        case (csr.araddr[4:2])
            A_CTRL:   rd_mux = {29'h0, ctrl_q};
            A_STATUS: rd_mux = {20'h0, err_q, busy, done_q, att_s, cmpl_s, rdy_s, sel_s, 3'h0};
            A_RESP:   rd_mux = {15'h0, resp_q};
            default:  rd_mux = 32'h0;
        endcase
    end

    assign interrupt         = done_q;
    assign esdi_transfer_req = req_q;
    assign esdi_command_data = cmd_data_q;
endmodule

// File: tb/tb_axi_esdi_cmd_master.sv
// Directed bench for axi_esdi_cmd_master with a simple drive-side handshake model.
`timescale 1ns/1ps
module tb_axi_esdi_cmd_master;
    localparam logic [4:0] R_CTRL = 5'h00, R_STATUS = 5'h04, R_CMD = 5'h08, R_RESP = 5'h0C, R_IRQ = 5'h10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_esdi_cmd_master_if bus();
    logic irq, req, cmd_data;
    logic ack = 1'b0, confstat = 1'b0;
    logic complete = 1'b0, attention = 1'b0, ready = 1'b1, selected = 1'b1;

    int tests_run = 0;
    int fails = 0;

    axi_esdi_cmd_master #(.DATA_SETUP(6), .ACK_TIMEOUT(100), .CMPL_TIMEOUT(300)) dut (
        .csr_aclk(clk), .csr_aresetn(rst_n), .csr(bus.slave), .interrupt(irq),
        .esdi_transfer_req(req), .esdi_command_data(cmd_data), .esdi_transfer_ack(ack),
        .esdi_confstat_data(confstat), .esdi_command_complete(complete),
        .esdi_attention(attention), .esdi_ready(ready), .esdi_drive_selected(selected)
    );

    // Drive model: ack 10 cycles after req; first 17 handshakes capture command bits, later ones return bfm_rx.
    bit          bfm_en = 1'b0;
    int          bfm_idx = 0;
    logic [16:0] bfm_cap = '0;
    logic [16:0] bfm_rx = '0;
    int          req_rises = 0;

    always @(posedge req) req_rises++;

    always begin
        @(negedge clk);
        if (!bfm_en) begin
            bfm_idx = 0;
            ack = 1'b0;
        end else if (req && !ack) begin
            repeat (10) @(negedge clk);
            if (bfm_idx < 17) bfm_cap = {bfm_cap[15:0], cmd_data};
            else confstat = bfm_rx[16 - (bfm_idx - 17)];
            ack = 1'b1;
            for (int n = 0; n < 200 && req; n++) @(negedge clk);
            repeat (2) @(negedge clk);
            ack = 1'b0;
            bfm_idx++;
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d);
        int k;
        bit aw_hs, w_hs;
        @(negedge clk);
        bus.awvalid = 1'b1; bus.awaddr = a; bus.wvalid = 1'b1; bus.wdata = d; bus.wstrb = 4'hF;
        bus.bready = 1'b1;
        k = 0;
        while ((bus.awvalid || bus.wvalid) && k < 20) begin
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(negedge clk);
            k++;
            if (aw_hs) bus.awvalid = 1'b0;
            if (w_hs) bus.wvalid = 1'b0;
        end
        k = 0;
        while (!bus.bvalid && k < 20) begin @(negedge clk); k++; end
        if (!bus.bvalid) begin
            tests_run++; fails++;
            $display("FAIL axi_write_timeout addr=%h: bvalid=%b, required 1", a, bus.bvalid);
        end
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        @(negedge clk);
        bus.bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        int k;
        @(negedge clk);
        bus.arvalid = 1'b1; bus.araddr = a; bus.rready = 1'b1;
        k = 0;
        while (!bus.arready && k < 20) begin @(negedge clk); k++; end
        @(negedge clk);
        bus.arvalid = 1'b0;
        k = 0;
        while (!bus.rvalid && k < 20) begin @(negedge clk); k++; end
        if (!bus.rvalid) begin
            tests_run++; fails++;
            $display("FAIL axi_read_timeout addr=%h: rvalid=%b, required 1", a, bus.rvalid);
        end
        d = bus.rdata;
        @(negedge clk);
        bus.rready = 1'b0;
    endtask

    task automatic bfm_rearm();
        bfm_en = 1'b0;
        repeat (20) @(negedge clk);
        bfm_en = 1'b1;
    endtask

    task automatic wait_idx(input int n);
        for (int k = 0; k < 3000 && bfm_idx < n; k++) @(negedge clk);
    endtask

    task automatic wait_irq();
        for (int k = 0; k < 400 && !irq; k++) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({req, cmd_data, irq} !== 3'b000) begin
            fails++; $display("FAIL reset_outputs: req/data/irq=%b, required 000", {req, cmd_data, irq});
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        axi_read(R_STATUS, d);
        tests_run++;
        if (d !== 32'h18) begin fails++; $display("FAIL reset_status: got %h, required 00000018", d); end
        axi_read(R_RESP, d);
        tests_run++;
        if (d !== 32'h0) begin fails++; $display("FAIL reset_resp: got %h, required 00000000", d); end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        axi_write(R_CTRL, 32'h2);
        bfm_rearm();
        axi_write(R_CMD, 32'h1234);
        axi_write(R_CMD, 32'hFFFF);
        axi_read(R_STATUS, d);
        tests_run++;
        if (d[8] !== 1'b1) begin fails++; $display("FAIL basic_busy: busy=%b, required 1", d[8]); end
        wait_idx(17);
        tests_run++;
        if (bfm_cap !== 17'h02468) begin fails++; $display("FAIL basic_bits: got %h, required 02468", bfm_cap); end
        repeat (10) @(negedge clk);
        tests_run++;
        if (irq !== 1'b0) begin fails++; $display("FAIL basic_wait_cmpl: irq=%b, required 0", irq); end
        complete = 1'b1;
        wait_irq();
        tests_run++;
        if (irq !== 1'b1) begin fails++; $display("FAIL basic_irq: irq=%b, required 1", irq); end
        axi_read(R_STATUS, d);
        tests_run++;
        if (d !== 32'hB8) begin fails++; $display("FAIL basic_status: got %h, required 000000b8", d); end
        complete = 1'b0;
        axi_write(R_IRQ, 32'h1);
        tests_run++;
        if (irq !== 1'b0) begin fails++; $display("FAIL basic_irq_clear: irq=%b, required 0", irq); end
    endtask

    task automatic test_status(input logic [16:0] rxw, input logic [31:0] exp_resp, input logic [31:0] exp_st);
        logic [31:0] d;
        axi_write(R_CTRL, 32'h6);
        bfm_rx = rxw;
        bfm_rearm();
        axi_write(R_CMD, 32'h0000);
        wait_idx(34);
        tests_run++;
        if (bfm_cap !== 17'h00001) begin fails++; $display("FAIL status_txbits: got %h, required 00001", bfm_cap); end
        complete = 1'b1;
        wait_irq();
        axi_read(R_RESP, d);
        tests_run++;
        if (d !== exp_resp) begin fails++; $display("FAIL status_resp: got %h, required %h", d, exp_resp); end
        axi_read(R_STATUS, d);
        tests_run++;
        if (d !== exp_st) begin fails++; $display("FAIL status_status: got %h, required %h", d, exp_st); end
        complete = 1'b0;
        axi_write(R_IRQ, 32'h1);
    endtask

    task automatic test_ack_timeout();
        logic [31:0] d;
        axi_write(R_CTRL, 32'h2);
        bfm_en = 1'b0;
        repeat (20) @(negedge clk);
        axi_write(R_CMD, 32'h1234);
        for (int k = 0; k < 50 && !req; k++) @(negedge clk);
        tests_run++;
        if (req !== 1'b1) begin fails++; $display("FAIL tmo_req_rise: req=%b, required 1", req); end
        wait_irq();
        tests_run++;
        if ({req, irq} !== 2'b01) begin fails++; $display("FAIL tmo_abort: req/irq=%b, required 01", {req, irq}); end
        axi_read(R_STATUS, d);
        tests_run++;
        if (d !== 32'h298) begin fails++; $display("FAIL tmo_status: got %h, required 00000298", d); end
        axi_write(R_IRQ, 32'h1);
    endtask

    task automatic test_not_ready();
        logic [31:0] d;
        int r0;
        ready = 1'b0;
        repeat (4) @(negedge clk);
        r0 = req_rises;
        axi_write(R_CMD, 32'h0F0F);
        axi_read(R_STATUS, d);
        tests_run++;
        if (d !== 32'hA88) begin fails++; $display("FAIL notready_status: got %h, required 00000a88", d); end
        repeat (20) @(negedge clk);
        tests_run++;
        if (req_rises != r0) begin fails++; $display("FAIL notready_noreq: req edges %0d, required %0d", req_rises, r0); end
        ready = 1'b1;
        axi_write(R_IRQ, 32'h1);
        repeat (4) @(negedge clk);
    endtask

    task automatic test_attention();
        logic [31:0] d;
        bfm_rearm();
        axi_write(R_CMD, 32'h0001);
        wait_idx(3);
        attention = 1'b1;
        repeat (6) @(negedge clk);
        attention = 1'b0;
        wait_idx(17);
        tests_run++;
        if (bfm_cap !== 17'h00002) begin fails++; $display("FAIL attn_bits: got %h, required 00002", bfm_cap); end
        complete = 1'b1;
        wait_irq();
        axi_read(R_STATUS, d);
        tests_run++;
        if (d !== 32'h8B8) begin fails++; $display("FAIL attn_status: got %h, required 000008b8", d); end
        complete = 1'b0;
        axi_write(R_IRQ, 32'h1);
    endtask

    task automatic test_soft_reset();
        logic [31:0] d;
        bfm_rearm();
        axi_write(R_CMD, 32'h8001);
        wait_idx(8);
        for (int k = 0; k < 40 && !req; k++) @(negedge clk);
        axi_write(R_CTRL, 32'h3);
        tests_run++;
        if (req !== 1'b0) begin fails++; $display("FAIL srst_req: req=%b, required 0", req); end
        axi_read(R_STATUS, d);
        tests_run++;
        if (d !== 32'h18) begin fails++; $display("FAIL srst_status: got %h, required 00000018", d); end
        axi_read(R_CTRL, d);
        tests_run++;
        if (d !== 32'h3) begin fails++; $display("FAIL srst_ctrl: got %h, required 00000003", d); end
        axi_write(R_CTRL, 32'h2);
        bfm_rearm();
        axi_write(R_CMD, 32'h00FF);
        wait_idx(17);
        tests_run++;
        if (bfm_cap !== 17'h001FF) begin fails++; $display("FAIL srst_rerun_bits: got %h, required 001ff", bfm_cap); end
        complete = 1'b1;
        wait_irq();
        axi_read(R_STATUS, d);
        tests_run++;
        if (d !== 32'hB8) begin fails++; $display("FAIL srst_rerun_status: got %h, required 000000b8", d); end
        complete = 1'b0;
        axi_write(R_IRQ, 32'h1);
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        axi_write(R_CTRL, 32'h6);
        bfm_rx = {16'hA5A5, 1'b1};
        bfm_rearm();
        axi_write(R_CMD, 32'h5A5A);
        wait_idx(20);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({req, cmd_data, irq, bus.awready, bus.bvalid, bus.rvalid} !== 6'b0) begin
            fails++;
            $display("FAIL arst_outputs: req/data/irq/awready/bvalid/rvalid=%b, required 000000",
                     {req, cmd_data, irq, bus.awready, bus.bvalid, bus.rvalid});
        end
        ready = 1'b0; selected = 1'b0; complete = 1'b0; bfm_en = 1'b0;
        repeat (20) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        axi_read(R_STATUS, d);
        tests_run++;
        if (d !== 32'h0) begin fails++; $display("FAIL arst_status: got %h, required 00000000", d); end
        axi_read(R_CTRL, d);
        tests_run++;
        if (d !== 32'h0) begin fails++; $display("FAIL arst_ctrl: got %h, required 00000000", d); end
    endtask

    initial begin
        bus.awvalid = 1'b0; bus.awaddr = '0; bus.awprot = '0;
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.bready = 1'b0;
        bus.arvalid = 1'b0; bus.araddr = '0; bus.arprot = '0; bus.rready = 1'b0;
        test_reset();
        test_basic();
        test_status({16'hA5A5, 1'b1}, 32'h0000A5A5, 32'h000000B8);
        test_status({16'hA5A5, 1'b0}, 32'h0001A5A5, 32'h000004B8);
        test_ack_timeout();
        test_not_ready();
        test_attention();
        test_soft_reset();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
